// File: rtl/cpu_regfile_xfer_if.sv
// Bus bundle between the CPU sequencer / RAM mux and the register file with burst engine.
// The master side is the sequencer plus RAM; the slave side is the register file itself.
interface cpu_regfile_xfer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 12
);
  logic [IDX_W-1:0]  rd_a_idx;
  logic [DATA_W-1:0] rd_a_data;
  logic [IDX_W-1:0]  rd_b_idx;
  logic [DATA_W-1:0] rd_b_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              flag_wr_en;
  logic [DATA_W-1:0] flag_data;
  logic              xfer_start;
  logic [1:0]        xfer_op;
  logic [IDX_W-1:0]  xfer_last;
  logic [ADDR_W-1:0] xfer_base;
  logic              xfer_busy;
  logic              xfer_done;
  logic              xfer_err;
  logic [ADDR_W-1:0] xfer_end_addr;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rd_a_idx, rd_b_idx, wr_en, wr_idx, wr_data, flag_wr_en, flag_data,
           xfer_start, xfer_op, xfer_last, xfer_base, mem_rdata,
    input  rd_a_data, rd_b_data, xfer_busy, xfer_done, xfer_err, xfer_end_addr,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  rd_a_idx, rd_b_idx, wr_en, wr_idx, wr_data, flag_wr_en, flag_data,
           xfer_start, xfer_op, xfer_last, xfer_base, mem_rdata,
    output rd_a_data, rd_b_data, xfer_busy, xfer_done, xfer_err, xfer_end_addr,
           mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cpu_regfile_xfer.sv
// CPU register file with two read ports, CPU/flag write ports and a burst engine that
// copies V0..Vlast to/from RAM (1-cycle read latency) or an internal RPL flag bank.
module cpu_regfile_xfer #(
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 4,
  parameter int ADDR_W    = 12,
  parameter int RPL_DEPTH = 8
) (
  input logic               clk,
  input logic               res,
  cpu_regfile_xfer_if.slave bus
);
  localparam int NREGS  = 2 ** IDX_W;
  localparam int CNT_W  = IDX_W + 1;
  localparam int RPL_IW = (RPL_DEPTH > 1) ? $clog2(RPL_DEPTH) : 1;
  localparam int RPL_N  = 2 ** RPL_IW;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] RPL_LIM = CNT_W'(RPL_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_ST,
    S_MEM_LD,
    S_RPL_ST,
    S_RPL_LD,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] regs [NREGS];
  // The RPL bank survives res on purpose: it models persistent flag storage.
  logic [DATA_W-1:0] rpl [RPL_N] = '{default: '0};

  logic [CNT_W-1:0]  k;
  logic [IDX_W-1:0]  last_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] end_addr_q;
  logic              err_q;

  logic [IDX_W-1:0]  k_idx;
  logic [RPL_IW-1:0] k_rpl;
  logic [CNT_W-1:0]  last_ext;
  logic [ADDR_W-1:0] addr_k;
  logic              beat_last;
  logic              last_oob;

  logic              start_go;
  logic              err_next;
  logic              busy;
  logic              rpl_wr;
  logic              eng_wr;
  logic [IDX_W-1:0]  eng_idx;
  logic [DATA_W-1:0] eng_data;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign k_idx     = k[IDX_W-1:0];
  assign k_rpl     = k[RPL_IW-1:0];
  assign last_ext  = {1'b0, last_q};
  assign addr_k    = base_q + ADDR_W'(k);
  assign beat_last = (k == last_ext);
  assign last_oob  = ({1'b0, bus.xfer_last} >= RPL_LIM);

  assign bus.rd_a_data     = regs[bus.rd_a_idx];
  assign bus.rd_b_data     = regs[bus.rd_b_idx];
  assign bus.xfer_busy     = busy;
  assign bus.xfer_done     = (state == S_DONE);
  assign bus.xfer_err      = err_q;
  assign bus.xfer_end_addr = end_addr_q;
  assign bus.mem_en        = mem_en;
  assign bus.mem_wr        = mem_wr;
  assign bus.mem_addr      = mem_addr;
  assign bus.mem_wdata     = mem_wdata;

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_IDLE;
    else     state <= state_next;
  end

  // RAM strobes are decoded from state so a reset mid-burst drops them without a clock.
  always_comb begin
    state_next = state;
    start_go   = 1'b0;
    err_next   = 1'b0;
    rpl_wr     = 1'b0;
    eng_wr     = 1'b0;
    eng_idx    = '0;
    eng_data   = '0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_IDLE: begin
        if (bus.xfer_start) begin
          if (bus.xfer_op[1] && last_oob) begin
            err_next = 1'b1;
          end else begin
            start_go = 1'b1;
            case (bus.xfer_op)
              2'd0:    state_next = S_MEM_ST;
              2'd1:    state_next = S_MEM_LD;
              2'd2:    state_next = S_RPL_ST;
              default: state_next = S_RPL_LD;
            endcase
          end
        end
      end
      S_MEM_ST: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_k;
        mem_wdata = regs[k_idx];
        if (beat_last) state_next = S_DONE;
      end
      S_MEM_LD: begin
        // Issue address j while capturing the data returned for address j-1.
        if (k <= last_ext) begin
          mem_en   = 1'b1;
          mem_addr = addr_k;
        end
        if (k != '0) begin
          eng_wr   = 1'b1;
          eng_idx  = k_idx - IDX_W'(1);
          eng_data = bus.mem_rdata;
        end
        if (k == last_ext + CNT_ONE) state_next = S_DONE;
      end
      S_RPL_ST: begin
        rpl_wr = 1'b1;
        if (beat_last) state_next = S_DONE;
      end
      S_RPL_LD: begin
        eng_wr   = 1'b1;
        eng_idx  = k_idx;
        eng_data = rpl[k_rpl];
        if (beat_last) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Burst bookkeeping plus the register array; CPU writes only land while idle.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      k          <= '0;
      last_q     <= '0;
      base_q     <= '0;
      end_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_next;
      if (start_go) begin
        k          <= '0;
        last_q     <= bus.xfer_last;
        base_q     <= bus.xfer_base;
        end_addr_q <= bus.xfer_base + ADDR_W'(bus.xfer_last) + ADDR_W'(1);
      end else if (busy) begin
        k <= k + CNT_ONE;
      end
      if (state == S_IDLE) begin
        if (bus.wr_en)      regs[bus.wr_idx] <= bus.wr_data;
        if (bus.flag_wr_en) regs[NREGS-1]    <= bus.flag_data;
      end
      if (eng_wr) regs[eng_idx] <= eng_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rpl_wr) rpl[k_rpl] <= regs[k_idx];
  end
endmodule

// File: tb/tb_cpu_regfile_xfer.sv
// Directed bench for cpu_regfile_xfer: RAM model, scoreboard of expected RAM writes,
// and immediate-assertion checks on register contents and engine status.
module tb_cpu_regfile_xfer;
  logic clk = 1'b0;
  logic res = 1'b1;

  always #5 clk = ~clk;

  cpu_regfile_xfer_if #(.DATA_W(8), .IDX_W(4), .ADDR_W(12)) bus ();

  cpu_regfile_xfer #(.DATA_W(8), .IDX_W(4), .ADDR_W(12), .RPL_DEPTH(8)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  ram [4096];
  logic [7:0]  ram_q;
  logic [7:0]  vals [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;

  // RAM with one cycle of read latency
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      ram_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = ram_q;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Every RAM write the DUT issues is matched against the scoreboard queue
  always @(negedge clk) begin
    if (bus.mem_en === 1'b1 && bus.mem_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_mem_wr", {20'd0, bus.mem_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check_output("mem_wr_addr", {20'd0, bus.mem_addr}, {20'd0, e.addr});
        check_output("mem_wr_data", {24'd0, bus.mem_wdata}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] idx, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = idx;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [3:0] ia, input logic [7:0] ea,
                           input logic [3:0] ib, input logic [7:0] eb);
    bus.rd_a_idx = ia;
    bus.rd_b_idx = ib;
    #1;
    check_output({tag, "_a"}, {24'd0, bus.rd_a_data}, {24'd0, ea});
    check_output({tag, "_b"}, {24'd0, bus.rd_b_data}, {24'd0, eb});
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [3:0] last, input logic [11:0] base);
    bus.xfer_start = 1'b1;
    bus.xfer_op    = op;
    bus.xfer_last  = last;
    bus.xfer_base  = base;
    tick();
    bus.xfer_start = 1'b0;
  endtask

  // Counts busy cycles until done, bounded so a stuck engine cannot hang the run
  task automatic wait_done(input int max, output int cycles);
    cycles = 0;
    while (bus.xfer_done !== 1'b1 && cycles < max) begin
      tick();
      cycles++;
    end
    if (bus.xfer_done !== 1'b1)
      check_output("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.rd_a_idx = '0; bus.rd_b_idx = '0;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.flag_wr_en = 1'b0; bus.flag_data = '0;
    bus.xfer_start = 1'b0; bus.xfer_op = '0; bus.xfer_last = '0; bus.xfer_base = '0;
    for (int i = 0; i < 8; i++) vals[i] = 8'(16 + 3 * i);

    // Power-on reset state
    @(posedge clk); #1;
    check_output("rst_busy", {31'd0, bus.xfer_busy}, 32'd0);
    check_output("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check_output("rst_end_addr", {20'd0, bus.xfer_end_addr}, 32'd0);
    res = 1'b0;
    tick();
    read_pair("rst_v0_v15", 4'd0, 8'h00, 4'd15, 8'h00);

    // Asynchronous reset clears registers without a clock edge
    cpu_write(4'd2, 8'h55);
    read_pair("pre_async_v2", 4'd2, 8'h55, 4'd0, 8'h00);
    res = 1'b1;
    #1;
    read_pair("async_rst_v2", 4'd2, 8'h00, 4'd0, 8'h00);
    check_output("async_rst_busy", {31'd0, bus.xfer_busy}, 32'd0);
    res = 1'b0;
    tick();

    // Store V0..V3 to 0x300..0x303
    cpu_write(4'd0, 8'h11); cpu_write(4'd1, 8'h22);
    cpu_write(4'd2, 8'h33); cpu_write(4'd3, 8'h44);
    exp_q.push_back('{12'h300, 8'h11}); exp_q.push_back('{12'h301, 8'h22});
    exp_q.push_back('{12'h302, 8'h33}); exp_q.push_back('{12'h303, 8'h44});
    apply_stimulus(2'd0, 4'd3, 12'h300);
    check_output("st_busy_first", {31'd0, bus.xfer_busy}, 32'd1);
    wait_done(40, n);
    check_output("st_busy_cycles", n, 32'd4);
    check_output("st_done_busy", {31'd0, bus.xfer_busy}, 32'd0);
    check_output("st_end_addr", {20'd0, bus.xfer_end_addr}, 32'h304);
    tick();

    // Load with address wrap 0xFFF -> 0x000
    ram[12'hFFE] = 8'hA1; ram[12'hFFF] = 8'hA2; ram[12'h000] = 8'hA3; ram[12'h001] = 8'hA4;
    apply_stimulus(2'd1, 4'd3, 12'hFFE);
    wait_done(40, n);
    check_output("ld_busy_cycles", n, 32'd5);
    check_output("ld_end_addr", {20'd0, bus.xfer_end_addr}, 32'h002);
    tick();
    read_pair("ld_v0_v1", 4'd0, 8'hA1, 4'd1, 8'hA2);
    read_pair("ld_v2_v3", 4'd2, 8'hA3, 4'd3, 8'hA4);

    // Simultaneous CPU and flag write to the flag register: flag wins
    bus.flag_wr_en = 1'b1; bus.flag_data = 8'h01;
    cpu_write(4'd15, 8'h05);
    bus.flag_wr_en = 1'b0;
    read_pair("flag_win", 4'd15, 8'h01, 4'd0, 8'hA1);

    // Writes and starts while busy are ignored
    exp_q.push_back('{12'h100, 8'hA1}); exp_q.push_back('{12'h101, 8'hA2});
    exp_q.push_back('{12'h102, 8'hA3}); exp_q.push_back('{12'h103, 8'hA4});
    apply_stimulus(2'd0, 4'd3, 12'h100);
    bus.wr_en = 1'b1; bus.wr_idx = 4'd0; bus.wr_data = 8'h77;
    bus.flag_wr_en = 1'b1; bus.flag_data = 8'h99;
    bus.xfer_start = 1'b1; bus.xfer_op = 2'd0; bus.xfer_last = 4'd0; bus.xfer_base = 12'h000;
    wait_done(40, n);
    bus.wr_en = 1'b0; bus.flag_wr_en = 1'b0; bus.xfer_start = 1'b0;
    check_output("busy_wr_cycles", n, 32'd4);
    tick();
    read_pair("busy_wr_ignored", 4'd0, 8'hA1, 4'd15, 8'h01);

    // RPL bank survives reset
    for (int i = 0; i < 8; i++) cpu_write(4'(i), vals[i]);
    apply_stimulus(2'd2, 4'd7, 12'h000);
    wait_done(40, n);
    check_output("rpl_st_cycles", n, 32'd8);
    tick();
    res = 1'b1; #2; res = 1'b0;
    tick();
    read_pair("rpl_cleared", 4'd0, 8'h00, 4'd7, 8'h00);
    apply_stimulus(2'd3, 4'd7, 12'h000);
    wait_done(40, n);
    check_output("rpl_ld_cycles", n, 32'd8);
    tick();
    read_pair("rpl_ld_v0_v7", 4'd0, vals[0], 4'd7, vals[7]);
    read_pair("rpl_ld_v3_v5", 4'd3, vals[3], 4'd5, vals[5]);

    // RPL op beyond the bank depth is rejected
    cpu_write(4'd0, 8'hEE);
    apply_stimulus(2'd2, 4'd8, 12'h000);
    check_output("rpl_err_pulse", {31'd0, bus.xfer_err}, 32'd1);
    check_output("rpl_err_busy", {31'd0, bus.xfer_busy}, 32'd0);
    tick();
    check_output("rpl_err_clear", {31'd0, bus.xfer_err}, 32'd0);
    check_output("rpl_err_busy2", {31'd0, bus.xfer_busy}, 32'd0);
    apply_stimulus(2'd3, 4'd7, 12'h000);
    wait_done(40, n);
    tick();
    read_pair("rpl_unchanged", 4'd0, vals[0], 4'd7, vals[7]);

    // Reset at beat 2 of a long store aborts immediately
    exp_q.push_back('{12'h200, vals[0]}); exp_q.push_back('{12'h201, vals[1]});
    apply_stimulus(2'd0, 4'd15, 12'h200);
    tick(); tick();
    check_output("abort_pre_mem_en", {31'd0, bus.mem_en}, 32'd1);
    res = 1'b1;
    #1;
    check_output("abort_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check_output("abort_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
    check_output("abort_busy", {31'd0, bus.xfer_busy}, 32'd0);
    res = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("abort_no_done", {31'd0, bus.xfer_done}, 32'd0);
    end

    // Single-beat store and load across the top of RAM
    cpu_write(4'd0, 8'h5A);
    exp_q.push_back('{12'hFFF, 8'h5A});
    apply_stimulus(2'd0, 4'd0, 12'hFFF);
    wait_done(20, n);
    check_output("single_st_cycles", n, 32'd1);
    check_output("single_end_addr", {20'd0, bus.xfer_end_addr}, 32'h000);
    tick();
    cpu_write(4'd0, 8'h00);
    apply_stimulus(2'd1, 4'd0, 12'hFFF);
    wait_done(20, n);
    check_output("single_ld_cycles", n, 32'd2);
    tick();
    read_pair("single_ld_v0", 4'd0, 8'h5A, 4'd1, vals[1] & 8'h00);

    tick();
    check_output("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
